// File: rtl/spi_master_v2.sv
// Parametrised SPI master: one full-duplex transfer per accepted valid/ready command.
// Supports any CPOL/CPHA mode, either bit order and NUM_SS active-low slave selects.
module spi_master_v2 #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int NUM_SS    = 2,
  localparam int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_n_o
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_data;
  logic [NUM_SS-1:0] ss_n;
  logic [NUM_SS-1:0] ss_mask;
  logic              sclk;
  logic              mosi;
  logic              div_last;
  logic              half_last;
  logic              lead_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign div_last  = (div_cnt == DIV_LAST);
  assign half_last = (half_cnt == HALF_LAST);
  // Even half-periods end on a leading SCLK edge, odd ones on a trailing edge.
  assign lead_edge = ~half_cnt[0];
  assign rx_next   = MSB_FIRST ? {rx_shift[DATA_W-2:0], miso_i}
                               : {miso_i, rx_shift[DATA_W-1:1]};

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ss_mask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel_i == SEL_W'(i)) ss_mask[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      ss_n     <= '1;
      sclk     <= CPOL;
      mosi     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            state    <= S_LEAD;
            div_cnt  <= '0;
            half_cnt <= '0;
            rx_shift <= '0;
            ss_n     <= ss_mask;
            if (!CPHA) begin
              mosi     <= first_bit(data_i);
              tx_shift <= drop_bit(data_i);
            end else begin
              mosi     <= 1'b0;
              tx_shift <= data_i;
            end
          end
        end
        S_LEAD: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) state <= S_XFER;
        end
        S_XFER: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Shift edge drives the next bit, the other edge captures miso.
            if (lead_edge == CPHA) begin
              if (!half_last) begin
                mosi     <= first_bit(tx_shift);
                tx_shift <= drop_bit(tx_shift);
              end
            end else begin
              rx_shift <= rx_next;
            end
            if (half_last) state <= S_TRAIL;
            else           half_cnt <= half_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state   <= S_DONE;
            ss_n    <= '1;
            mosi    <= 1'b0;
            rx_data <= rx_shift;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (state == S_IDLE);
  assign busy_o    = ~ready_o;
  assign done_o    = (state == S_DONE);
  assign sclk_o    = sclk;
  assign mosi_o    = mosi;
  assign ss_n_o    = ss_n;
  assign rx_data_o = rx_data;

endmodule

// File: tb/tb_spi_master_v2.sv
// Bench for spi_master_v2: six differently parametrised masters, each checked
// against a bit-sequence/timing model of an SPI transfer and a behavioural slave.
module tb_spi_master_v2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  valid, lb, miso_drv;
  logic [15:0] din [6];
  logic [1:0]  sel [6];

  wire [5:0]  ready, busy, done, sclk, mosi;
  wire [7:0]  rx0, rx1, rx2, rx3, rx5;
  wire [15:0] rx4;
  wire [3:0]  ss0;
  wire [1:0]  ss1, ss2, ss3, ss4;
  wire [2:0]  ss5;
  wire [15:0] rx  [6];
  wire [3:0]  ssn [6];

  assign rx[0] = {8'h0, rx0};
  assign rx[1] = {8'h0, rx1};
  assign rx[2] = {8'h0, rx2};
  assign rx[3] = {8'h0, rx3};
  assign rx[4] = rx4;
  assign rx[5] = {8'h0, rx5};
  assign ssn[0] = ss0;
  assign ssn[1] = {2'b11, ss1};
  assign ssn[2] = {2'b11, ss2};
  assign ssn[3] = {2'b11, ss3};
  assign ssn[4] = {2'b11, ss4};
  assign ssn[5] = {1'b1, ss5};

  spi_master_v2 #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .NUM_SS(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[0]), .ready_o(ready[0]), .data_i(din[0][7:0]),
    .ss_sel_i(sel[0]), .rx_data_o(rx0), .done_o(done[0]), .busy_o(busy[0]), .sclk_o(sclk[0]),
    .mosi_o(mosi[0]), .miso_i(lb[0] ? mosi[0] : miso_drv[0]), .ss_n_o(ss0));
  spi_master_v2 #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .NUM_SS(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[1]), .ready_o(ready[1]), .data_i(din[1][7:0]),
    .ss_sel_i(sel[1][0]), .rx_data_o(rx1), .done_o(done[1]), .busy_o(busy[1]), .sclk_o(sclk[1]),
    .mosi_o(mosi[1]), .miso_i(lb[1] ? mosi[1] : miso_drv[1]), .ss_n_o(ss1));
  spi_master_v2 #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1), .NUM_SS(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[2]), .ready_o(ready[2]), .data_i(din[2][7:0]),
    .ss_sel_i(sel[2][0]), .rx_data_o(rx2), .done_o(done[2]), .busy_o(busy[2]), .sclk_o(sclk[2]),
    .mosi_o(mosi[2]), .miso_i(lb[2] ? mosi[2] : miso_drv[2]), .ss_n_o(ss2));
  spi_master_v2 #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .NUM_SS(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[3]), .ready_o(ready[3]), .data_i(din[3][7:0]),
    .ss_sel_i(sel[3][0]), .rx_data_o(rx3), .done_o(done[3]), .busy_o(busy[3]), .sclk_o(sclk[3]),
    .mosi_o(mosi[3]), .miso_i(lb[3] ? mosi[3] : miso_drv[3]), .ss_n_o(ss3));
  spi_master_v2 #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .NUM_SS(2)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[4]), .ready_o(ready[4]), .data_i(din[4]),
    .ss_sel_i(sel[4][0]), .rx_data_o(rx4), .done_o(done[4]), .busy_o(busy[4]), .sclk_o(sclk[4]),
    .mosi_o(mosi[4]), .miso_i(lb[4] ? mosi[4] : miso_drv[4]), .ss_n_o(ss4));
  spi_master_v2 #(.DATA_W(8), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .NUM_SS(3)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid[5]), .ready_o(ready[5]), .data_i(din[5][7:0]),
    .ss_sel_i(sel[5]), .rx_data_o(rx5), .done_o(done[5]), .busy_o(busy[5]), .sclk_o(sclk[5]),
    .mosi_o(mosi[5]), .miso_i(lb[5] ? mosi[5] : miso_drv[5]), .ss_n_o(ss5));

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chained  = 1'b0;
  int          last_done = 0;
  logic [15:0] last_rx [6];

  function automatic int p_dw(input int k);   return (k == 4) ? 16 : 8; endfunction
  function automatic int p_cd(input int k);   return (k == 5) ? 1 : 2; endfunction
  function automatic int p_nss(input int k);  return (k == 0) ? 4 : ((k == 5) ? 3 : 2); endfunction
  function automatic bit p_cpol(input int k); return (k == 2) || (k == 3); endfunction
  function automatic bit p_cpha(input int k); return (k == 1) || (k == 3); endfunction
  function automatic bit p_msb(input int k);  return (k != 4); endfunction

  // j-th bit on the wire for word w, in the instance's shift order.
  function automatic logic wire_bit(input logic [15:0] w, input int dw, input bit msb, input int j);
    return msb ? w[dw-1-j] : w[j];
  endfunction

  // One transfer on instance k; slave either loops mosi back or returns slave_w.
  task automatic run_xfer(input int k, input logic [15:0] tx, input logic [15:0] slave_w,
                          input logic [1:0] s, input bit loop_en, input bit hold,
                          input logic [15:0] ntx, input logic [1:0] nsel, input string tag);
    int dw, cd, len, n, q, done_cnt, done_at, bad_ss, bad_sclk, bad_rdy, nsamp, mi;
    bit cpol, cpha, msb, leading;
    logic prev, lead_mosi, done_mosi;
    logic [15:0] got_tx, exp_rx, dmask, rx_before, rx_done;
    logic [3:0] ss_exp;
    dw = p_dw(k); cd = p_cd(k); cpol = p_cpol(k); cpha = p_cpha(k); msb = p_msb(k);
    len = cd * (2 * dw + 2);
    dmask = (dw == 16) ? 16'hFFFF : 16'h00FF;
    exp_rx = (loop_en ? tx : slave_w) & dmask;
    ss_exp = 4'hF;
    if (int'(s) < p_nss(k)) ss_exp[s] = 1'b0;
    done_cnt = 0; done_at = -1; bad_ss = 0; bad_sclk = 0; bad_rdy = 0; nsamp = 0; mi = 0;
    got_tx = '0; lead_mosi = 1'bx; done_mosi = 1'bx; rx_before = 'x; rx_done = 'x;

    @(negedge clk);
    lb[k] = loop_en; din[k] = tx; sel[k] = s; valid[k] = 1'b1;
    miso_drv[k] = 1'b0;
    if (!cpha) begin
      miso_drv[k] = wire_bit(slave_w, dw, msb, 0);
      mi = 1;
    end
    n = cyc;
    n_checks++;
    if (ready[k] !== 1'b1 || sclk[k] !== cpol) begin
      n_fail++;
      $display("FAIL %s accept_idle: ready=%b sclk=%b required ready=1 sclk=%b", tag, ready[k], sclk[k], cpol);
    end
    if (chained) begin
      n_checks++;
      if (n != last_done + 1) begin
        n_fail++;
        $display("FAIL %s b2b_accept_cycle: got %0d required %0d", tag, n, last_done + 1);
      end
    end
    prev = cpol;
    for (int t = 1; t <= len + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (hold) begin din[k] = ntx; sel[k] = nsel; end
        else valid[k] = 1'b0;
        lead_mosi = mosi[k];
      end
      if (ssn[k] !== ((t <= len) ? ss_exp : 4'hF)) bad_ss++;
      q = (t - 1) / cd - 1;
      if (q < 0) q = 0;
      if (q > 2 * dw) q = 2 * dw;
      if (sclk[k] !== (cpol ^ q[0])) bad_sclk++;
      if (ready[k] !== 1'b0 || busy[k] !== 1'b1) bad_rdy++;
      if (sclk[k] !== prev) begin
        leading = (prev == cpol);
        if (leading != cpha) begin
          if (nsamp < dw) got_tx[msb ? dw - 1 - nsamp : nsamp] = mosi[k];
          nsamp++;
        end else begin
          if (mi < dw) miso_drv[k] = wire_bit(slave_w, dw, msb, mi);
          mi++;
        end
      end
      prev = sclk[k];
      if (done[k] === 1'b1) begin done_cnt++; done_at = cyc; end
      if (t == len) rx_before = rx[k];
      if (t == len + 1) begin rx_done = rx[k]; done_mosi = mosi[k]; end
    end

    n_checks++;
    if (done_cnt != 1 || done_at != n + 1 + len) begin
      n_fail++;
      $display("FAIL %s done_timing: pulses=%0d at cycle %0d, required 1 pulse at cycle %0d", tag, done_cnt, done_at, n + 1 + len);
    end
    n_checks++;
    if (rx_done !== exp_rx) begin
      n_fail++;
      $display("FAIL %s rx_data: got %h required %h", tag, rx_done, exp_rx);
    end
    n_checks++;
    if (rx_before !== last_rx[k]) begin
      n_fail++;
      $display("FAIL %s rx_hold: got %h required %h", tag, rx_before, last_rx[k]);
    end
    n_checks++;
    if (got_tx !== (tx & dmask) || nsamp != dw) begin
      n_fail++;
      $display("FAIL %s mosi_bits: got %h (%0d samples) required %h (%0d samples)", tag, got_tx, nsamp, tx & dmask, dw);
    end
    n_checks++;
    if (lead_mosi !== (cpha ? 1'b0 : wire_bit(tx, dw, msb, 0)) || done_mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL %s mosi_lead_done: lead=%b done=%b required lead=%b done=0", tag, lead_mosi, done_mosi,
               cpha ? 1'b0 : wire_bit(tx, dw, msb, 0));
    end
    n_checks++;
    if (bad_ss != 0 || bad_sclk != 0 || bad_rdy != 0) begin
      n_fail++;
      $display("FAIL %s waveform: bad ss=%0d sclk=%0d ready/busy=%0d cycles, required 0/0/0", tag, bad_ss, bad_sclk, bad_rdy);
    end
    last_rx[k] = exp_rx;
    chained    = hold;
    last_done  = done_at;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({ready[k], busy[k], done[k], sclk[k], mosi[k], ssn[k], rx[k]} !==
          {1'b1, 1'b0, 1'b0, p_cpol(k), 1'b0, 4'hF, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: rdy=%b busy=%b done=%b sclk=%b mosi=%b ss=%h rx=%h required 1 0 0 %b 0 f 0000",
                 k, ready[k], busy[k], done[k], sclk[k], mosi[k], ssn[k], rx[k], p_cpol(k));
      end
      last_rx[k] = '0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mode0();
    run_xfer(0, 16'h00A5, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0, 2'd0, "mode0_a5");
  endtask

  task automatic test_modes();
    for (int k = 0; k < 4; k++) run_xfer(k, 16'h00C3, 16'h003C, 2'(k % 2), 1'b0, 1'b0, 16'h0, 2'd0, "modes_3c");
  endtask

  task automatic test_lsb_first();
    run_xfer(4, 16'h8001, 16'h0000, 2'd1, 1'b1, 1'b0, 16'h0, 2'd0, "lsb_8001");
    run_xfer(4, 16'h1234, 16'hBEEF, 2'd0, 1'b0, 1'b0, 16'h0, 2'd0, "lsb_slave");
  endtask

  task automatic test_ss_select();
    run_xfer(0, 16'h0096, 16'h0069, 2'd2, 1'b0, 1'b1, 16'h00E7, 2'd3, "ss_sel2_hold");
    run_xfer(0, 16'h00E7, 16'h0018, 2'd3, 1'b0, 1'b0, 16'h0, 2'd0, "ss_sel3");
    run_xfer(5, 16'h004B, 16'h00D2, 2'd3, 1'b0, 1'b0, 16'h0, 2'd0, "ss_out_of_range");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk);
    lb[0] = 1'b1; din[0] = 16'h005A; sel[0] = 2'd1; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    n_checks++;
    if (ssn[0] !== 4'b1101 || sclk[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_xfer_state: ss=%h sclk=%b required ss=d sclk=1", ssn[0], sclk[0]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ssn[0], sclk[0], mosi[0], ready[0], done[0], rx[0]} !== {4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_abort: ss=%h sclk=%b mosi=%b rdy=%b done=%b rx=%h required f 0 0 1 0 0000",
               ssn[0], sclk[0], mosi[0], ready[0], done[0], rx[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 6'b0 || ready !== 6'h3F) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d cycles with done or busy after reset, required 0", done_seen);
    end
    for (int k = 0; k < 6; k++) last_rx[k] = '0;
    chained = 1'b0;
    run_xfer(0, 16'h00C6, 16'h0000, 2'd3, 1'b1, 1'b0, 16'h0, 2'd0, "post_reset");
  endtask

  task automatic test_back_to_back();
    run_xfer(5, 16'h0011, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0022, 2'd1, "b2b_first");
    run_xfer(5, 16'h0022, 16'h0000, 2'd1, 1'b1, 1'b0, 16'h0, 2'd0, "b2b_second");
  endtask

  task automatic test_random();
    int k;
    logic [1:0] s;
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 5));
      s = (k == 5) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, p_nss(k) - 1));
      run_xfer(k, 16'($urandom), 16'($urandom), s, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 2'd0, "random");
    end
  endtask

  initial begin
    valid = '0; lb = '0; miso_drv = '0;
    for (int k = 0; k < 6; k++) begin din[k] = '0; sel[k] = '0; last_rx[k] = '0; end
    test_reset();
    test_mode0();
    test_modes();
    test_lsb_first();
    test_ss_select();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
